// File: rtl/tiny16_pkg.sv
// tiny16_pkg: opcodes, system codes, branch conditions, states and decode helpers
package tiny16_pkg;
  typedef enum logic [2:0] {BOOT, F0, F1, E0, E1, E2, HALT, IRQ} state_t;
  typedef enum logic [3:0] {
    OP_SYS = 4'd0, OP_LD = 4'd1, OP_ST = 4'd2, OP_JMP = 4'd12,
    OP_JSR = 4'd13, OP_CMP = 4'd14, OP_BR = 4'd15
  } op_t;
  typedef enum logic [3:0] {
    SYS_NOP = 4'd0, SYS_IN = 4'd1, SYS_OUT = 4'd2, SYS_SET = 4'd3,
    SYS_CLR = 4'd4, SYS_HLT = 4'd15
  } sys_t;
  typedef enum logic [2:0] {BR_Z, BR_NZ, BR_N, BR_NN, BR_C, BR_NC, BR_V, BR_NV} br_cond_t;
  typedef enum logic [1:0] {M_IMM, M_IND, M_REG} mode_t;
  typedef struct packed {
    logic alu_out_en, alu_ar_flag, mem_addr_en, mem_in_en, mem_out_en, reg_in_en;
    logic reg_out_en, reg_pc_inc, ctl_out_en, dsp_in_en, halted, irq_ack;
  } strobe_t;
  localparam logic [3:0] OP_ALU_LO = 4'd3;
  localparam logic [3:0] OP_ALU_HI = 4'd11;
  localparam logic [3:0] OP_SH0 = 4'd10;
  localparam logic [3:0] OP_SH1 = 4'd11;
  localparam logic [3:0] ALU_CMP = 4'd4;
  function automatic mode_t mode_of(input logic b11, input logic b7);
    return !b11 ? M_IMM : b7 ? M_IND : M_REG;
  endfunction
  function automatic logic is_alu(input logic [3:0] op);
    return (op >= OP_ALU_LO && op <= OP_ALU_HI) || op == OP_CMP;
  endfunction
  function automatic logic [1:0] steps(input logic [15:7] i);
    mode_t m;
    m = mode_of(i[11], i[7]);
    return i[15:12] == OP_ST || i[15:12] == OP_JSR ? 2'd2 :
           is_alu(i[15:12]) ? (m == M_IMM ? 2'd2 : m == M_IND ? 2'd3 : 2'd1) :
           i[15:12] == OP_LD || i[15:12] == OP_BR ? (m == M_IND ? 2'd2 : 2'd1) :
           i[15:12] == OP_SYS && i[11:8] == SYS_OUT && i[7] ? 2'd2 : 2'd1;
  endfunction
endpackage

// File: rtl/branch_eval.sv
// branch_eval: condition code selects a flag (Z,N,C,V from bit 3 down), low bit inverts it
module branch_eval (
  input  logic [2:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);
  assign taken = flags[2'd3 - cond[2:1]] ^ cond[0];
endmodule

// File: rtl/ctl_sequencer.sv
// ctl_sequencer: variable-length tiny16 fetch/decode/execute controller; CTL_IRQ_EN adds interrupt entry
module ctl_sequencer
  import tiny16_pkg::*;
#(
  parameter int          WIDTH      = 16,
  parameter int          REG_SEL_W  = 3,
  parameter logic [15:0] IRQ_VECTOR = 16'h0010
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in,
  input  logic [3:0]           flags,
  input  logic                 irq,
  output logic [3:0]           alu_opcode,
  output logic                 alu_out_en,
  output logic                 alu_ar_flag,
  output logic                 mem_addr_en,
  output logic                 mem_in_en,
  output logic                 mem_out_en,
  output logic [REG_SEL_W-1:0] reg_src_sel,
  output logic [REG_SEL_W-1:0] reg_dst_sel,
  output logic                 reg_in_en,
  output logic                 reg_out_en,
  output logic                 reg_pc_inc,
  output logic                 ctl_out_en,
  output logic                 dsp_in_en,
  output logic [WIDTH-1:0]     out,
  output logic                 halted,
  output logic                 irq_ack,
  output logic [2:0]           state
);
  localparam logic [REG_SEL_W-1:0] TMP = '1;
  localparam logic [REG_SEL_W-1:0] R1 = REG_SEL_W'(1);
  state_t st, n, done;
  logic [15:0] inst, ni;
  logic [3:0] op, c_alu;
  logic [1:0] k;
  logic [REG_SEL_W-1:0] sr, dr, x, c_src, c_dst;
  logic [WIDTH-1:0] c_out;
  logic br, take, ph, np, alu, we;
  mode_t m;
  strobe_t c, q;
  branch_eval u_br (.cond(in[10:8]), .flags(flags), .taken(br));
  assign {alu_out_en, alu_ar_flag, mem_addr_en, mem_in_en, mem_out_en, reg_in_en,
          reg_out_en, reg_pc_inc, ctl_out_en, dsp_in_en, halted, irq_ack} = q;
  assign state = st;
  assign done = take ? IRQ : F0;
`ifdef CTL_IRQ_EN
  logic ie;
  assign take = irq && ie;
  // ie follows SET/CLR and drops on interrupt entry; ph walks IRQ0 -> IRQ1
  always_ff @(posedge clk or posedge rst)
    if (rst) {ie, ph} <= '0;
    else begin
      ie <= n == IRQ && st != IRQ ? 1'b0 :
            st == E0 && inst[15:12] == OP_SYS && inst[11:8] == SYS_SET ? 1'b1 :
            st == E0 && inst[15:12] == OP_SYS && inst[11:8] == SYS_CLR ? 1'b0 : ie;
      ph <= st == IRQ && !ph;
    end
`else
  logic unused_irq;
  assign unused_irq = irq;
  assign take = 1'b0;
  assign ph = 1'b0;
`endif
  // next state: instruction length comes from the latched instruction, branches/halt from the bus
  always_comb begin
    n = st;
    case (st)
      BOOT: n = F0;
      F0:   n = F1;
      F1:   n = in[15:12] == OP_SYS && in[11:8] == SYS_HLT ? HALT :
                in[15:12] == OP_BR && !br ? done : E0;
      E0:   n = steps(inst[15:7]) > 2'd1 ? E1 : done;
      E1:   n = steps(inst[15:7]) > 2'd2 ? E2 : done;
      E2:   n = done;
      HALT: n = take ? IRQ : HALT;
      IRQ:  n = ph ? F0 : IRQ;
    endcase
  end
  // controls for the state being entered, so the registered strobes line up with it
  always_comb begin
    ni = st == F1 ? in[15:0] : inst;
    op = ni[15:12];
    np = st == IRQ && !ph;
    m = mode_of(ni[11], ni[7]);
    alu = is_alu(op);
    we = op != OP_CMP;
    k = n == E0 ? 2'd0 : n == E1 ? 2'd1 : 2'd2;
    sr = REG_SEL_W'(ni[6:4]);
    dr = REG_SEL_W'(ni[10:8]);
    x = alu ? TMP : op == OP_BR ? '0 : dr;
    c = '0;
    c_alu = '0;
    c_src = '0;
    c_dst = '0;
    c_out = WIDTH'(n == IRQ ? IRQ_VECTOR : op == OP_JMP || op == OP_JSR ? {4'h0, ni[11:0]} : {8'h0, ni[7:0]});
    case (n)
      F0:   {c.reg_out_en, c.mem_addr_en} = 2'b11;
      F1:   {c.mem_out_en, c.reg_pc_inc} = 2'b11;
      HALT: c.halted = 1'b1;
      IRQ:  if (!np) {c.reg_out_en, c.reg_in_en, c_dst} = {2'b11, R1};
            else {c.ctl_out_en, c.reg_in_en, c.irq_ack} = 3'b111;
      E0, E1, E2: begin
        if (alu) begin
          c_alu = op == OP_CMP ? ALU_CMP : op;
          c.alu_ar_flag = (op == OP_SH0 || op == OP_SH1) && ni[11];
        end
        if (op == OP_LD || op == OP_BR || alu) begin
          if (alu && k == steps(ni[15:7]) - 2'd1) {c.alu_out_en, c.reg_in_en, c_dst} = {1'b1, we, dr};
          else if (m == M_IMM) {c.ctl_out_en, c.reg_in_en, c_dst} = {2'b11, x};
          else if (m == M_IND && k == 2'd0) {c.reg_out_en, c.mem_addr_en, c_src} = {2'b11, sr};
          else if (m == M_IND) {c.mem_out_en, c.reg_in_en, c_dst} = {2'b11, x};
          else {c.reg_out_en, c.reg_in_en, c_src, c_dst} = {2'b11, sr, x};
        end else if (op == OP_ST) begin
          if (k == 2'd0) {c.reg_out_en, c.mem_addr_en, c_src} = {2'b11, sr};
          else {c.reg_out_en, c.mem_in_en, c_src} = {2'b11, dr};
        end else if (op == OP_JMP) {c.ctl_out_en, c.reg_in_en} = 2'b11;
        else if (op == OP_JSR) begin
          if (k == 2'd0) {c.reg_out_en, c.reg_in_en, c_dst} = {2'b11, R1};
          else {c.ctl_out_en, c.reg_in_en} = 2'b11;
        end else if (op == OP_SYS && ni[11:8] == SYS_OUT) begin
          if (ni[7] && k == 2'd0) {c.reg_out_en, c.mem_addr_en, c_src} = {2'b11, sr};
          else if (ni[7]) {c.mem_out_en, c.dsp_in_en} = 2'b11;
          else {c.reg_out_en, c.dsp_in_en, c_src} = {2'b11, sr};
        end
      end
      default: ;
    endcase
  end
  // state, instruction and all control outputs register together; reset clears everything at once
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= BOOT;
      inst <= '0;
      q <= '0;
      alu_opcode <= '0;
      reg_src_sel <= '0;
      reg_dst_sel <= '0;
      out <= '0;
    end else begin
      st <= n;
      inst <= ni;
      q <= c;
      alu_opcode <= c_alu;
      reg_src_sel <= c_src;
      reg_dst_sel <= c_dst;
      out <= c_out;
    end
endmodule

// File: tb/tb_ctl_sequencer.sv
// tb_ctl_sequencer: directed per-cycle checks of ctl_sequencer strobes; CTL_IRQ_EN selects the interrupt scenario
module tb_ctl_sequencer;
  logic clk = 0, rst = 1, irq = 0;
  logic [15:0] in = '0, out;
  logic [3:0] flags = '0, alu_opcode;
  logic alu_out_en, alu_ar_flag, mem_addr_en, mem_in_en, mem_out_en;
  logic reg_in_en, reg_out_en, reg_pc_inc, ctl_out_en, dsp_in_en, halted, irq_ack;
  logic [2:0] reg_src_sel, reg_dst_sel, state;
  logic [11:0] strb;
  int n_chk = 0, n_bad = 0;
  localparam logic [11:0] ALU = 12'h800, AR = 12'h400, MA = 12'h200, MI = 12'h100, MO = 12'h080, RI = 12'h040;
  localparam logic [11:0] RO = 12'h020, PI = 12'h010, CO = 12'h008, DI = 12'h004, HL = 12'h002, IA = 12'h001;
  localparam logic [2:0] S_BOOT = 0, S_F0 = 1, S_F1 = 2, S_E0 = 3, S_E1 = 4, S_E2 = 5, S_HALT = 6, S_IRQ = 7;
  ctl_sequencer dut (
    .clk(clk), .rst(rst), .in(in), .flags(flags), .irq(irq),
    .alu_opcode(alu_opcode), .alu_out_en(alu_out_en), .alu_ar_flag(alu_ar_flag),
    .mem_addr_en(mem_addr_en), .mem_in_en(mem_in_en), .mem_out_en(mem_out_en),
    .reg_src_sel(reg_src_sel), .reg_dst_sel(reg_dst_sel), .reg_in_en(reg_in_en),
    .reg_out_en(reg_out_en), .reg_pc_inc(reg_pc_inc), .ctl_out_en(ctl_out_en),
    .dsp_in_en(dsp_in_en), .out(out), .halted(halted), .irq_ack(irq_ack), .state(state)
  );
  assign strb = {alu_out_en, alu_ar_flag, mem_addr_en, mem_in_en, mem_out_en, reg_in_en,
                 reg_out_en, reg_pc_inc, ctl_out_en, dsp_in_en, halted, irq_ack};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic ex(input string tag, input logic [2:0] s, input logic [11:0] b,
                    input logic [2:0] src = 3'd0, input logic [2:0] dst = 3'd0);
    step;
    chk({tag, ".state"}, state, s);
    chk({tag, ".strb"}, strb, b);
    chk({tag, ".src"}, reg_src_sel, src);
    chk({tag, ".dst"}, reg_dst_sel, dst);
  endtask
  task automatic ins(input string tag, input logic [15:0] v);
    in = v;
    ex({tag, ".f1"}, S_F1, MO | PI);
  endtask
  task automatic zero_check(input string tag);
    chk({tag, ".state"}, state, S_BOOT);
    chk({tag, ".strb"}, strb, 0);
    chk({tag, ".alu"}, alu_opcode, 0);
    chk({tag, ".sel"}, {reg_src_sel, reg_dst_sel}, 0);
    chk({tag, ".out"}, out, 0);
  endtask
  initial begin
    step;
    step;
    zero_check("reset");
    in = 16'h1105;
    rst = 0;
    ex("ld_imm.f0", S_F0, RO | MA);
    ex("ld_imm.f1", S_F1, MO | PI);
    ex("ld_imm.e0", S_E0, CO | RI, 0, 1);
    chk("ld_imm.out", out, 16'h0005);
    ex("ld_imm.done", S_F0, RO | MA);
    ins("st", 16'h2230);
    ex("st.e0", S_E0, RO | MA, 3, 0);
    ex("st.e1", S_E1, RO | MI, 2, 0);
    ex("st.done", S_F0, RO | MA);
    ins("ld_reg", 16'h1920);
    ex("ld_reg.e0", S_E0, RO | RI, 2, 1);
    ex("ld_reg.done", S_F0, RO | MA);
    ins("ld_ind", 16'h1AB0);
    ex("ld_ind.e0", S_E0, RO | MA, 3, 0);
    ex("ld_ind.e1", S_E1, MO | RI, 0, 2);
    ex("ld_ind.done", S_F0, RO | MA);
    ins("add_imm", 16'h3305);
    ex("add_imm.e0", S_E0, CO | RI, 0, 7);
    ex("add_imm.e1", S_E1, ALU | RI, 0, 3);
    chk("add_imm.op", alu_opcode, 3);
    ex("add_imm.done", S_F0, RO | MA);
    ins("add_ind", 16'h3BA0);
    ex("add_ind.e0", S_E0, RO | MA, 2, 0);
    ex("add_ind.e1", S_E1, MO | RI, 0, 7);
    ex("add_ind.e2", S_E2, ALU | RI, 0, 3);
    chk("add_ind.op", alu_opcode, 3);
    ex("add_ind.done", S_F0, RO | MA);
    ins("sh_ar", 16'hA910);
    ex("sh_ar.e0", S_E0, ALU | AR | RI, 0, 1);
    chk("sh_ar.op", alu_opcode, 10);
    ex("sh_ar.done", S_F0, RO | MA);
    ins("cmp", 16'hE912);
    ex("cmp.e0", S_E0, ALU, 0, 1);
    chk("cmp.op", alu_opcode, 4);
    ex("cmp.done", S_F0, RO | MA);
    ins("jmp", 16'hC123);
    ex("jmp.e0", S_E0, CO | RI, 0, 0);
    chk("jmp.out", out, 16'h0123);
    ex("jmp.done", S_F0, RO | MA);
    ins("jsr", 16'hD456);
    ex("jsr.e0", S_E0, RO | RI, 0, 1);
    ex("jsr.e1", S_E1, CO | RI, 0, 0);
    chk("jsr.out", out, 16'h0456);
    ex("jsr.done", S_F0, RO | MA);
    flags = 4'b0000;
    ins("bz_nt", 16'hF004);
    ex("bz_nt.done", S_F0, RO | MA);
    flags = 4'b1000;
    ins("bz_t", 16'hF004);
    ex("bz_t.e0", S_E0, CO | RI, 0, 0);
    chk("bz_t.out", out, 16'h0004);
    ex("bz_t.done", S_F0, RO | MA);
    flags = 4'b0010;
    ins("bnc_nt", 16'hF507);
    ex("bnc_nt.done", S_F0, RO | MA);
    flags = 4'b0000;
    ins("bnc_t", 16'hF507);
    ex("bnc_t.e0", S_E0, CO | RI, 0, 0);
    ex("bnc_t.done", S_F0, RO | MA);
    ins("out_reg", 16'h0230);
    ex("out_reg.e0", S_E0, RO | DI, 3, 0);
    ex("out_reg.done", S_F0, RO | MA);
    ins("hlt", 16'h0F00);
    for (int i = 0; i < 100; i++) ex("hlt.hold", S_HALT, HL);
    rst = 1;
    #1;
    zero_check("hlt.rst");
    step;
    rst = 0;
    ex("hlt.boot", S_F0, RO | MA);
    ins("set", 16'h0300);
    ex("set.e0", S_E0, 0);
    ex("set.done", S_F0, RO | MA);
    irq = 1;
    ins("irq_add", 16'h3BA0);
    ex("irq_add.e0", S_E0, RO | MA, 2, 0);
    ex("irq_add.e1", S_E1, MO | RI, 0, 7);
    ex("irq_add.e2", S_E2, ALU | RI, 0, 3);
`ifdef CTL_IRQ_EN
    ex("irq0", S_IRQ, RO | RI, 0, 1);
    chk("irq0.out", out, 16'h0010);
    ex("irq1", S_IRQ, CO | RI | IA, 0, 0);
    chk("irq1.out", out, 16'h0010);
    ex("irq.done", S_F0, RO | MA);
    ins("irq.masked", 16'h1920);
    ex("irq.masked.e0", S_E0, RO | RI, 2, 1);
    ex("irq.masked.done", S_F0, RO | MA);
`else
    ex("irq_off.done", S_F0, RO | MA);
    ins("irq_off.next", 16'h1920);
    ex("irq_off.e0", S_E0, RO | RI, 2, 1);
    ex("irq_off.f0", S_F0, RO | MA);
`endif
    irq = 0;
    ins("abort", 16'h3BA0);
    ex("abort.e0", S_E0, RO | MA, 2, 0);
    ex("abort.e1", S_E1, MO | RI, 0, 7);
    rst = 1;
    #1;
    zero_check("abort.rst");
    step;
    rst = 0;
    ex("abort.boot", S_F0, RO | MA);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
